// File: rtl/ldl_fifo_ws_v1.sv
// Write-side pointer and flag controller of a split-pointer FIFO (publishes w_pt, consumes r_pt).
// Define LDL_FIFO_WS_OVF_EN to build the sticky overflow flag; otherwise ovf is tied low.
module ldl_fifo_ws_v1 #(
  parameter int AW       = 8,
  parameter int AFULL_TH = 2**AW - 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  output logic          full,
  output logic          afull,
  output logic [AW-1:0] wa,
  output logic          mw,
  output logic [AW:0]   w_pt,
  input  logic [AW:0]   r_pt,
  output logic [AW:0]   wcnt,
  output logic [AW:0]   peak,
  input  logic          peak_clr,
  output logic          ovf,
  input  logic          ovf_clr
);

  localparam int            DEPTH   = 2**AW;
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
  localparam logic [AW+1:0] AFULL_W = (AW+2)'(AFULL_TH);

  logic [AW:0]   w_pt_q, w_pt_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic [AW:0]   peak_q, peak_d;
  logic          fw;
  logic [AW+1:0] nxt;

  assign fw   = we & ~full_q;
  assign wcnt = w_pt_q - r_pt;

  // Flags look at the occupancy after this cycle's write but before any read
  // the consumer may retire now; that read only shows up once r_pt moves.
  always_comb begin
    nxt     = {1'b0, wcnt} + {{(AW+1){1'b0}}, fw};
    w_pt_d  = w_pt_q + {{AW{1'b0}}, fw};
    full_d  = (nxt >= DEPTH_W);
    afull_d = (nxt >= AFULL_W);
    if (peak_clr) begin
      peak_d = nxt[AW:0];
    end else if (nxt > {1'b0, peak_q}) begin
      peak_d = nxt[AW:0];
    end else begin
      peak_d = peak_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_pt_q  <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      peak_q  <= '0;
    end else begin
      w_pt_q  <= w_pt_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      peak_q  <= peak_d;
    end
  end

  assign mw    = fw;
  assign wa    = w_pt_q[AW-1:0];
  assign w_pt  = w_pt_q;
  assign full  = full_q;
  assign afull = afull_q;
  assign peak  = peak_q;

`ifdef LDL_FIFO_WS_OVF_EN
  logic ovf_q, ovf_d;

  // A set in the same cycle as a clear must survive.
  always_comb begin
    ovf_d = (we & full_q) | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf            = 1'b0;
`endif

endmodule

// File: doc/ldl_fifo_ws_v1.md
Name: ldl_fifo_ws_v1

Overview:
- Write-side pointer and flag controller of the split-pointer FIFO.
- Sits directly upstream of the read-side controller. Accepts producer write requests and generates the RAM write strobe and address. Publishes `w_pt` to the read side and consumes `r_pt` from it.
- Provides registered `full` and `afull` flags, fill level, and a peak-occupancy watermark for debug.

Parameters:
- `AW`, 8: address width; `DEPTH = 2**AW` entries.
- `AFULL_TH`, `2**AW - 2`: almost-full threshold in entries. Legal range 1..DEPTH.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `we`  in  1  write request from producer.
- `full`  out  1  registered; FIFO cannot accept a write.
- `afull`  out  1  registered; occupancy >= `AFULL_TH`.
- `wa`  out  AW  RAM write address.
- `mw`  out  1  RAM write strobe, combinational.
- `w_pt`  out  AW+1  write pointer, registered, with wrap bit.
- `r_pt`  in  AW+1  read pointer from read side.
- `wcnt`  out  AW+1  current occupancy, combinational.
- `peak`  out  AW+1  registered maximum occupancy since last clear.
- `peak_clr`  in  1  synchronous clear of `peak`.
- `ovf`  out  1  sticky overflow flag; see Optional Feature.
- `ovf_clr`  in  1  synchronous clear of `ovf`.

Behaviour:
- Reset: `rst` high at a clock edge gives `w_pt=0`, `full=0`, `afull=0`, `peak=0`, `ovf=0`. `rst` overrides every other input in that cycle.
- Accepted write: `fw = we & ~full`. `mw = fw`. `wa = w_pt[AW-1:0]`, i.e. data is written at the current pointer. On `fw`, `w_pt <= w_pt + 1`, modulo 2^(AW+1). The wrap bit toggles every DEPTH writes.
- Occupancy: `wcnt = w_pt - r_pt`, modulo 2^(AW+1), range 0..DEPTH. Define `nxt = wcnt + fw`, computed at AW+2 bits so there is no overflow.
- Full: `full <= (nxt >= DEPTH)`, evaluated against the current `r_pt`.
  - A read retiring in the same cycle is not visible until `r_pt` updates.
  - `full` may therefore stay high one extra cycle. This is conservative and never admits a write into a full FIFO.
  - Latency: a write filling the last entry gives `full=1` on the next edge. A read from a full FIFO gives `full=0` two edges later.
- Almost full: `afull <= (nxt >= AFULL_TH)`, same timing as `full`. With `AFULL_TH = DEPTH`, `afull` equals `full`.
- Write while full: `we=1` with `full=1` is dropped. `mw=0` and `w_pt` holds.
- Peak watermark:
  - Each cycle, `peak <= max(peak, nxt)`.
  - With `peak_clr=1`, `peak <= nxt`. The clear wins over the max, and the current level is captured.
- Empty FIFO: `wcnt=0`. `full` and `afull` deassert per the formulas above. No special state.
- Wrap: all pointer arithmetic is modulo 2^(AW+1). The full/empty distinction relies solely on the wrap bit.
- Reset mid-burst: pointer returns to 0 immediately. The read side must be reset in the same cycle; this is a system-level rule, not checked by this block.
- No FSM. State consists of `w_pt`, the flag registers, `peak` and `ovf`.

Optional Feature:
- Macro: `LDL_FIFO_WS_OVF_EN`.
- Defined:
  - `ovf` sets on any cycle with `we & full`, and stays set until `ovf_clr=1`.
  - If set and clear occur in the same cycle, set wins.
- Undefined: `ovf` is tied to 0, `ovf_clr` is ignored, and no register is inferred.

Test Plan:
- `AW=2`, `AFULL_TH=3`, reset then 4 back-to-back writes with `r_pt=0` → `wa` = 0,1,2,3; `afull` rises after the 3rd write edge; `full=1` after the 4th; `w_pt=4`, `wcnt=4`.
- Full FIFO, `we=1` for 2 cycles → `mw=0`, `w_pt` holds at 4; with macro defined `ovf=1` persists until a `ovf_clr` pulse, without macro `ovf` stays 0.
- Full FIFO, `r_pt` steps 0→1 → `full` deasserts on the edge after `r_pt` changes; the next write goes to `wa=0` and `w_pt` becomes 5 (wrap bit set).
- 10 writes with `r_pt` tracking 1 behind (steady `wcnt=1`) → `w_pt` wraps 7→0; `full` and `afull` never assert; `peak=2`.
- Fill to 3, drain to 0, pulse `peak_clr` → `peak` reads 3 before the clear and 0 after.
- Assert `rst` mid-burst at `w_pt=3` with `we=1` → next cycle `w_pt=0`, `full=0`, `afull=0`, `peak=0`, `ovf=0`; the write issued in the reset cycle is not counted.
